// File: rtl/cp0_timer_unit.sv
// rtl/cp0_timer_unit.sv - CP0 Count/Compare timer with NUM_CMP channels, prescaler, auto-reload and W1C pending
module cp0_timer_unit #(
   parameter int NUM_CMP  = 2,
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               wen,
   input  logic [4:0]         waddr,
   input  logic [31:0]        wdata,
   input  logic [4:0]         raddr,
   output logic [31:0]        rdata,
   input  logic               cnt_halt,
   output logic [NUM_CMP-1:0] irq,
   output logic               irq_any
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   logic [CNT_W-1:0]   count;
   logic               en;
   logic [NUM_CMP-1:0] ar;
   logic [NUM_CMP-1:0] pend;
   logic [NUM_CMP-1:0] mask;
   logic [NUM_CMP-1:0] match_q;
   logic [CNT_W-1:0]   compare [NUM_CMP];
   logic [CNT_W-1:0]   period  [NUM_CMP];
   logic [PW-1:0]      presc;

   logic               tick;
   logic               wr_count, wr_ctrl, wr_pend, wr_mask;
   logic [NUM_CMP-1:0] wr_cmp, wr_per;
   logic [NUM_CMP-1:0] match_now, hit, clr;

   always_comb begin
      tick     = (presc == PRESC_MAX) && en && !cnt_halt;
      wr_count = wen && (waddr == 5'd0);
      wr_ctrl  = wen && (waddr == 5'd1);
      wr_pend  = wen && (waddr == 5'd2);
      wr_mask  = wen && (waddr == 5'd3);
      wr_cmp   = '0;
      wr_per   = '0;
      match_now = '0;
      hit       = '0;
      for (int i = 0; i < NUM_CMP; i++) begin
         wr_cmp[i]    = wen && (waddr == 5'(4 + 2*i));
         wr_per[i]    = wen && (waddr == 5'(5 + 2*i));
         match_now[i] = (count == compare[i]);
         // Edge-detected so a persisting match pends only once
         hit[i]       = match_now[i] && !match_q[i] && en;
      end
      // Compare writes acknowledge the timer interrupt, as on MIPS
      clr = (wr_pend ? wdata[NUM_CMP-1:0] : '0) | wr_cmp;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count   <= '0;
         presc   <= '0;
         en      <= 1'b0;
         ar      <= '0;
         pend    <= '0;
         mask    <= '0;
         match_q <= '0;
         for (int i = 0; i < NUM_CMP; i++) begin
            compare[i] <= '1;
            period[i]  <= '0;
         end
      end else begin
         if (wr_count) begin
            count <= wdata[CNT_W-1:0];
            presc <= '0;
         end else if (tick) begin
            count <= count + CNT_W'(1);
            presc <= '0;
         end else if (en && !cnt_halt) begin
            presc <= presc + PW'(1);
         end
         if (wr_ctrl) begin
            en <= wdata[0];
            ar <= wdata[8 +: NUM_CMP];
         end
         if (wr_mask)
            mask <= wdata[NUM_CMP-1:0];
         pend    <= (pend & ~clr) | hit;
         match_q <= match_now;
         for (int i = 0; i < NUM_CMP; i++) begin
            if (wr_cmp[i])
               compare[i] <= wdata[CNT_W-1:0];
            else if (hit[i] && ar[i])
               compare[i] <= compare[i] + period[i];
            if (wr_per[i])
               period[i] <= wdata[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (raddr == 5'd0) begin
         rdata = 32'(count);
      end else if (raddr == 5'd1) begin
         rdata[0]            = en;
         rdata[8 +: NUM_CMP] = ar;
      end else if (raddr == 5'd2) begin
         rdata[NUM_CMP-1:0] = pend;
      end else if (raddr == 5'd3) begin
         rdata[NUM_CMP-1:0] = mask;
      end else begin
         for (int i = 0; i < NUM_CMP; i++) begin
            if (raddr == 5'(4 + 2*i))
               rdata = 32'(compare[i]);
            else if (raddr == 5'(5 + 2*i))
               rdata = 32'(period[i]);
         end
      end
   end

   assign irq     = pend & mask;
   assign irq_any = |irq;

endmodule

// File: tb/tb_cp0_timer_unit.sv
// tb/tb_cp0_timer_unit.sv - directed vector bench for cp0_timer_unit
module tb_cp0_timer_unit;

   localparam int OP_W = 0, OP_R = 1, OP_C = 2, OP_I = 3, OP_H = 4;

   typedef struct {
      int          op;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn, wen, cnt_halt;
   logic [4:0]  waddr, raddr;
   logic [31:0] wdata, rdata, rdata1;
   logic [1:0]  irq, irq1;
   logic        irq_any, irq_any1;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   cp0_timer_unit u_dut (
      .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .cnt_halt(cnt_halt), .irq(irq), .irq_any(irq_any)
   );

   cp0_timer_unit #(.PRESCALE(1)) u_p1 (
      .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata1), .cnt_halt(cnt_halt), .irq(irq1), .irq_any(irq_any1)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      @(posedge clk);
      #1;
      wen = 1'b0;
   endtask

   function automatic void add(input int op, input logic [4:0] a, input logic [31:0] d,
                               input logic [31:0] e, input string nm);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = nm;
      tbl.push_back(v);
   endfunction

   initial begin
      resetn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0; cnt_halt = 1'b0;

      add(OP_R, 0,  0, 32'h0,        "rst_count");
      add(OP_R, 1,  0, 32'h0,        "rst_ctrl");
      add(OP_R, 2,  0, 32'h0,        "rst_pend");
      add(OP_R, 3,  0, 32'h0,        "rst_mask");
      add(OP_R, 4,  0, 32'hFFFFFFFF, "rst_cmp0");
      add(OP_R, 5,  0, 32'h0,        "rst_per0");
      add(OP_R, 6,  0, 32'hFFFFFFFF, "rst_cmp1");
      add(OP_R, 31, 0, 32'h0,        "rst_addr31");
      add(OP_I, 0,  0, 32'h0,        "rst_irq");
      add(OP_W, 8,  5, 0, "");
      add(OP_R, 8,  0, 32'h0,        "oor_addr8");
      add(OP_W, 1,  32'hFFFFFFFE, 0, "");
      add(OP_R, 1,  0, 32'h00000300, "ctrl_bits");
      // prescaler: 20 clocks at PRESCALE=2 give 10 counts
      add(OP_W, 1,  1, 0, "");
      add(OP_C, 0, 20, 0, "");
      add(OP_R, 0,  0, 32'd10,       "presc_count");
      add(OP_H, 0,  1, 0, "");
      add(OP_C, 0,  6, 0, "");
      add(OP_R, 0,  0, 32'd10,       "halt_count");
      add(OP_H, 0,  0, 0, "");
      add(OP_W, 1,  0, 0, "");
      add(OP_C, 0,  4, 0, "");
      add(OP_R, 0,  0, 32'd10,       "dis_count");
      // one-shot match at COUNT=5
      add(OP_W, 3,  1, 0, "");
      add(OP_W, 4,  5, 0, "");
      add(OP_W, 0,  0, 0, "");
      add(OP_W, 1,  1, 0, "");
      add(OP_C, 0, 10, 0, "");
      add(OP_R, 0,  0, 32'd5,        "os_count5");
      add(OP_R, 2,  0, 32'd0,        "os_pend_lat");
      add(OP_C, 0,  1, 0, "");
      add(OP_R, 2,  0, 32'd1,        "os_pend");
      add(OP_I, 0,  0, 32'd5,        "os_irq");
      add(OP_W, 2,  1, 0, "");
      add(OP_R, 2,  0, 32'd0,        "os_once");
      add(OP_W, 4,  8, 0, "");
      add(OP_C, 0,  3, 0, "");
      add(OP_R, 0,  0, 32'd8,        "os_count8");
      add(OP_R, 2,  0, 32'd0,        "os_pend8_lat");
      add(OP_C, 0,  1, 0, "");
      add(OP_R, 2,  0, 32'd1,        "os_pend8");
      add(OP_W, 4, 100, 0, "");
      add(OP_R, 2,  0, 32'd0,        "cmp_ack");
      add(OP_I, 0,  0, 32'd0,        "cmp_ack_irq");
      // periodic: COMPARE0=3, PERIOD0=4
      add(OP_W, 1,  0, 0, "");
      add(OP_W, 5,  4, 0, "");
      add(OP_W, 4,  3, 0, "");
      add(OP_W, 0,  0, 0, "");
      add(OP_W, 2,  1, 0, "");
      add(OP_W, 1, 32'h101, 0, "");
      add(OP_C, 0,  6, 0, "");
      add(OP_R, 0,  0, 32'd3,        "per_count3");
      add(OP_R, 2,  0, 32'd0,        "per_pend3_lat");
      add(OP_C, 0,  1, 0, "");
      add(OP_R, 2,  0, 32'd1,        "per_pend3");
      add(OP_R, 4,  0, 32'd7,        "per_cmp7");
      add(OP_I, 0,  0, 32'd5,        "per_irq");
      add(OP_W, 2,  1, 0, "");
      add(OP_R, 2,  0, 32'd0,        "per_w1c");
      add(OP_C, 0,  6, 0, "");
      add(OP_R, 0,  0, 32'd7,        "per_count7");
      add(OP_C, 0,  1, 0, "");
      add(OP_R, 2,  0, 32'd1,        "per_pend7");
      add(OP_R, 4,  0, 32'd11,       "per_cmp11");
      add(OP_W, 2,  1, 0, "");
      add(OP_C, 0,  6, 0, "");
      add(OP_R, 0,  0, 32'd11,       "per_count11");
      add(OP_C, 0,  1, 0, "");
      add(OP_R, 2,  0, 32'd1,        "per_pend11");
      add(OP_R, 4,  0, 32'd15,       "per_cmp15");

      step(2);
      resetn = 1'b1;

      foreach (tbl[k]) begin
         case (tbl[k].op)
            OP_W: wr(tbl[k].addr, tbl[k].data);
            OP_R: begin
               raddr = tbl[k].addr;
               #1;
               chk(tbl[k].name, rdata, tbl[k].exp);
            end
            OP_C: step(int'(tbl[k].data));
            OP_I: begin
               #1;
               chk(tbl[k].name, 32'({irq_any, irq}), tbl[k].exp);
            end
            default: cnt_halt = tbl[k].data[0];
         endcase
      end

      // wrap and W1C/set collision, checked on the PRESCALE=1 instance
      wr(1, 0);
      wr(3, 2);
      wr(6, 0);
      wr(0, 32'hFFFFFFFF);
      wr(2, 3);
      wr(1, 1);
      step(1);
      raddr = 0; #1;
      chk("wrap_count_p1", rdata1, 32'h0);
      chk("wrap_hold_p2", rdata, 32'hFFFFFFFF);
      raddr = 2; #1;
      chk("wrap_pend_lat", rdata1 & 32'h2, 32'h0);
      wr(2, 2);
      raddr = 2; #1;
      chk("collision_pend", rdata1 & 32'h2, 32'h2);
      chk("collision_irq", 32'(irq1[1]), 32'h1);
      raddr = 0; #1;
      chk("p1_count1", rdata1, 32'h1);
      step(1);
      raddr = 2; #1;
      chk("p2_wrap_pend", rdata, 32'h2);
      chk("p2_wrap_irq", 32'({irq_any, irq}), 32'h6);

      // asynchronous reset between clock edges
      step(4);
      raddr = 0; #1;
      chk("pre_arst_count", rdata, 32'd2);
      #20;
      resetn = 1'b0;
      #1;
      chk("arst_count", rdata, 32'h0);
      chk("arst_irq", 32'({irq_any, irq}), 32'h0);
      raddr = 2; #1;
      chk("arst_pend", rdata, 32'h0);
      raddr = 4; #1;
      chk("arst_cmp0", rdata, 32'hFFFFFFFF);
      step(1);
      resetn = 1'b1;
      step(2);
      raddr = 0; #1;
      chk("post_arst_count", rdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_timer_unit.md
Name: cp0_timer_unit

Overview:
- Parametrised CP0 timer/interrupt source. Generalises the single Count/Compare pair to NUM_CMP compare channels.
- Adds a configurable prescaler, per-channel auto-reload (periodic) mode, a W1C pending register, a mask register and a debug halt.
- Sits beside the CP0 register file. It is accessed through the same 5-bit mtc0/mfc0-style write/read port, and it drives interrupt lines into Cause.IP.

Parameters:
NUM_CMP, 2, number of compare channels (1..8)
CNT_W, 32, width of COUNT/COMPARE/PERIOD registers
PRESCALE, 2, clk cycles per COUNT increment (>=1)

Ports:
clk  in  1  single clock; all state updates on posedge
resetn  in  1  reset, asynchronous, active-low
wen  in  1  register write strobe (already qualified by pipeline valid)
waddr  in  5  write address
wdata  in  32  write data (low CNT_W bits used for counter regs)
raddr  in  5  read address
rdata  out  32  combinational read of addressed register, zero-extended; unmapped -> 0
cnt_halt  in  1  debug freeze: prescaler and COUNT hold while 1
irq  out  NUM_CMP  pend & mask, per channel
irq_any  out  1  OR of irq

Behaviour:
- Clock and reset: one clock clk; reset resetn is asynchronous, active-low.
- Register map:
  - 0 COUNT
  - 1 CTRL: bit0 EN; bit 8+i AR[i]; other bits read 0
  - 2 PEND: bit i, W1C
  - 3 MASK: bit i
  - 4+2i COMPARE[i]
  - 5+2i PERIOD[i]
- Reset values:
  - COUNT=0, CTRL=0, PEND=0, MASK=0, PERIOD=0.
  - COMPARE=all-ones, prescaler=0, match history=0.
  - Outputs: irq=0, irq_any=0; rdata reflects reset regs.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1 and cnt_halt=0; holds otherwise.
  - tick = (presc==PRESCALE-1) & EN & ~cnt_halt; presc wraps to 0 on tick.
  - With PRESCALE=1, tick every enabled cycle.
- COUNT:
  - Increments by 1 on tick, modulo 2^CNT_W (all-ones -> 0).
  - A COUNT write wins over tick: loads wdata, resets presc to 0, no increment that cycle.
- Match detect, per channel i:
  - match_now = (COUNT==COMPARE[i]); match_q <= match_now every cycle.
  - edge = match_now & ~match_q & EN.
- Pending set:
  - edge sets PEND[i] in the next cycle.
  - Because detection is edge-based, an equal-value COUNT or COMPARE write also sets PEND if EN=1.
  - A match that persists sets PEND only once.
- Pending clear:
  - Writing PEND with bit i=1 clears PEND[i].
  - Writing COMPARE[i] clears PEND[i] (MIPS timer-ack semantics).
  - Set beats clear: if edge and any clear hit the same cycle, PEND[i]=1.
- Auto-reload:
  - If AR[i]=1 on edge, COMPARE[i] <= COMPARE[i]+PERIOD[i] (mod 2^CNT_W).
  - A software COMPARE[i] write in the same cycle wins over the reload.
  - PERIOD[i]=0 gives one-shot behaviour: compare is unchanged, so no new edge occurs.
- Disabling: clearing EN freezes COUNT and presc and blocks new PEND sets. Existing PEND is kept.
- Latency:
  - A write in cycle N is visible on rdata in N+1.
  - A match edge in cycle N gives PEND and irq high in N+1.
  - irq and irq_any are combinational from PEND and MASK.
- Unmapped and out-of-range addresses: writes are ignored; reads return 0. This includes channel addresses >= 4+2*NUM_CMP.
- Reset assertion mid-operation returns every register to its reset value immediately, independent of clk.

Test Plan:
- Reset/readback: hold resetn=0, then release. Read all addresses -> COUNT=0, CTRL=0, PEND=0, COMPARE0=0xFFFFFFFF, addr 31=0; irq=0.
- Prescale count: PRESCALE=2, write CTRL=1, then run 20 cycles -> COUNT=10. Assert cnt_halt for 6 cycles -> COUNT unchanged.
- One-shot match: MASK=1, COMPARE0=5, COUNT=0, EN=1 -> PEND[0]=1 and irq[0]=1 one cycle after COUNT reaches 5, set only once. Write COMPARE0=100 -> PEND[0]=0.
- Periodic: AR0=1, PERIOD0=4, COMPARE0=3 -> PEND edges at COUNT=3, 7, 11, with W1C PEND=1 after each. COMPARE0 reads 15 after the third edge.
- Wrap and collision: COUNT=0xFFFFFFFF, COMPARE1=0, PRESCALE=1 -> COUNT=0 next tick and PEND[1] set. Issue a W1C of bit1 in the same cycle as the edge -> PEND[1] stays 1.
- Async reset mid-run: drop resetn between clk edges during counting -> COUNT, PEND and irq go to 0 without a clock edge.
